// File: rtl/parking_fee_unit.sv
// parking_fee_unit
//  Ticketing and fee stage of the car park. Each entering car gets the lowest free
//  ticket slot and its entry time is stamped. On exit the stay is priced (every
//  started time unit is billed), the fee is held until payment, then the slot is
//  released.
//
//  Optional feature macro: PARKING_FEE_CAP_EN
//    defined   -> cost = min(width-saturated fee, MAX_FEE)
//    undefined -> only saturation to 2^CW-1 applies
//
//  Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   entry_evt     in : car passed the entry bar (1-cycle pulse)
//   entry_ack     out: ticket issued next cycle, ticket_id valid
//   entry_err     out: no free slot, no ticket issued
//   ticket_id     out: last issued slot, held until the next entry_ack
//   exit_req      in : car at exit, exit_id names its slot (accepted only when idle)
//   exit_id       in : slot to settle
//   exit_err      out: exit_id out of range or slot not occupied
//   cost          out: fee of the current settle, held until the next pricing
//   cost_valid    out: high while waiting for payment
//   pay           in : payment done, sampled only while waiting for payment
//   paid          out: 1-cycle pulse, slot released, exit bar may open
//   busy          out: a settle is in progress
module parking_fee_unit #(
   parameter int PMAX           = 5,
   parameter int TW             = 16,
   parameter int TICKS_PER_UNIT = 60,
   parameter int RATE           = 2,
   parameter int CW             = 8,
   parameter int MAX_FEE        = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          entry_evt,
   output logic          entry_ack,
   output logic          entry_err,
   output logic [2:0]    ticket_id,
   input  logic          exit_req,
   input  logic [2:0]    exit_id,
   output logic          exit_err,
   output logic [CW-1:0] cost,
   output logic          cost_valid,
   input  logic          pay,
   output logic          paid,
   output logic          busy
);

   localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
   // Fee arithmetic is wide enough that RATE * (2^TW) can never overflow.
   localparam int FW = TW + 34;
   localparam logic [FW-1:0] SAT_FEE = FW'((64'd1 << CW) - 64'd1);
`ifdef PARKING_FEE_CAP_EN
   localparam logic [FW-1:0] CAP_FEE = (FW'(MAX_FEE) < SAT_FEE) ? FW'(MAX_FEE) : SAT_FEE;
`else
   // Without the cap the only ceiling is the cost width.
   localparam logic [FW-1:0] CAP_FEE = (MAX_FEE > 0) ? SAT_FEE : SAT_FEE;
`endif

   typedef enum logic [1:0] {IDLE, CALC, WAIT_PAY, RELEASE} state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   presc;
   logic [TW-1:0]   now;
   logic [PMAX-1:0] occupied;
   logic [PMAX-1:0] occupied_next;
   logic [TW-1:0]   stamp [PMAX];
   logic [2:0]      sel_slot;
   logic [TW-1:0]   sel_stamp;
   logic            free_found;
   logic [2:0]      free_idx;
   logic            exit_ok;
   logic            alloc;
   logic            accept_exit;
   logic [TW-1:0]   dur;
   logic [TW:0]     units;
   logic [FW-1:0]   fee_wide;
   logic [FW-1:0]   fee_clamp;

   // Lowest free slot, valid-exit check and stamp of the slot being settled. Loops
   // compare indices so slot numbers >= PMAX never index the tables.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = PMAX - 1; i >= 0; i--) begin
         if (!occupied[i]) begin
            free_found = 1'b1;
            free_idx   = 3'(i);
         end
      end
      exit_ok   = 1'b0;
      sel_stamp = '0;
      for (int i = 0; i < PMAX; i++) begin
         if (exit_id == 3'(i) && occupied[i]) begin
            exit_ok = 1'b1;
         end
         if (sel_slot == 3'(i)) begin
            sel_stamp = stamp[i];
         end
      end
   end

   assign alloc       = entry_evt && free_found;
   assign accept_exit = (state == IDLE) && exit_req && exit_ok;

   // The releasing slot stays occupied through the RELEASE cycle, so an entry in
   // that cycle cannot take it; both updates target different bits.
   always_comb begin
      occupied_next = occupied;
      for (int i = 0; i < PMAX; i++) begin
         if (state == RELEASE && sel_slot == 3'(i)) begin
            occupied_next[i] = 1'b0;
         end
         if (alloc && free_idx == 3'(i)) begin
            occupied_next[i] = 1'b1;
         end
      end
   end

   // Modular subtraction keeps the stay correct across a wrap of now; the started
   // unit is billed, so a zero-length stay still costs one unit.
   always_comb begin
      dur       = now - sel_stamp;
      units     = {1'b0, dur} + (TW + 1)'(1);
      fee_wide  = FW'(RATE) * FW'(units);
      fee_clamp = (fee_wide > CAP_FEE) ? CAP_FEE : fee_wide;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      cost_valid = 1'b0;
      paid       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (exit_req && exit_ok) begin
               state_next = CALC;
            end
         end
         CALC: begin
            state_next = WAIT_PAY;
         end
         WAIT_PAY: begin
            cost_valid = 1'b1;
            if (pay) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            paid       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         now       <= '0;
         occupied  <= '0;
         ticket_id <= '0;
         entry_ack <= 1'b0;
         entry_err <= 1'b0;
         exit_err  <= 1'b0;
         sel_slot  <= '0;
         cost      <= '0;
         for (int i = 0; i < PMAX; i++) begin
            stamp[i] <= '0;
         end
      end else begin
         if (presc == PW'(TICKS_PER_UNIT - 1)) begin
            presc <= '0;
            now   <= now + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         entry_ack <= alloc;
         entry_err <= entry_evt && !free_found;
         exit_err  <= (state == IDLE) && exit_req && !exit_ok;
         occupied  <= occupied_next;
         if (alloc) begin
            ticket_id <= free_idx;
         end
         for (int i = 0; i < PMAX; i++) begin
            if (alloc && free_idx == 3'(i)) begin
               stamp[i] <= now;
            end
         end
         if (accept_exit) begin
            sel_slot <= exit_id;
         end
         if (state == CALC) begin
            cost <= CW'(fee_clamp);
         end
      end
   end

endmodule

// File: tb/tb_parking_fee_unit.sv
// tb_parking_fee_unit
//  Self-checking bench for parking_fee_unit: a table of directed vectors, a few
//  hand-written multi-cycle sequences, and a randomized run compared every cycle
//  against a behavioural model of the ticketing and settle rules.
//  A narrow timestamp (TW=8) keeps the time-wrap case within a short run.
module tb_parking_fee_unit;

   localparam int PMAX    = 5;
   localparam int TW      = 8;
   localparam int TPU     = 4;
   localparam int RATE    = 2;
   localparam int CW      = 8;
   localparam int MAX_FEE = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          entry_evt = 1'b0;
   logic          entry_ack;
   logic          entry_err;
   logic [2:0]    ticket_id;
   logic          exit_req = 1'b0;
   logic [2:0]    exit_id = '0;
   logic          exit_err;
   logic [CW-1:0] cost;
   logic          cost_valid;
   logic          pay = 1'b0;
   logic          paid;
   logic          busy;

   parking_fee_unit #(
      .PMAX(PMAX), .TW(TW), .TICKS_PER_UNIT(TPU), .RATE(RATE), .CW(CW), .MAX_FEE(MAX_FEE)
   ) dut (
      .clk(clk), .rst(rst),
      .entry_evt(entry_evt), .entry_ack(entry_ack), .entry_err(entry_err), .ticket_id(ticket_id),
      .exit_req(exit_req), .exit_id(exit_id), .exit_err(exit_err),
      .cost(cost), .cost_valid(cost_valid), .pay(pay), .paid(paid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       entry;
      logic       exit_req;
      logic [2:0] exit_id;
      logic       pay;
   } stim_t;

   typedef struct packed {
      logic          entry_ack;
      logic          entry_err;
      logic [2:0]    ticket_id;
      logic          exit_err;
      logic [CW-1:0] cost;
      logic          cost_valid;
      logic          paid;
      logic          busy;
   } outs_t;

   typedef struct {
      stim_t stim;
      outs_t exp;
   } vec_t;

   // Settle progress of the model, in the order the stay is handled.
   localparam int NO_SETTLE = 0;
   localparam int PRICING   = 1;
   localparam int AWAIT_PAY = 2;
   localparam int RELEASING = 3;

   int    n_tests = 0;
   int    n_fail  = 0;

   bit    m_occ [PMAX];
   int    m_stamp [PMAX];
   int    m_cyc;
   int    m_stage;
   int    m_slot;
   outs_t m_exp;

   function automatic stim_t mk(input logic r, input logic e, input logic x,
                                input int id, input logic p);
      stim_t s;
      s.rst = r; s.entry = e; s.exit_req = x; s.exit_id = 3'(id); s.pay = p;
      return s;
   endfunction

   function automatic outs_t mo(input logic ack, input logic err, input int tid,
                                input logic xerr, input int c, input logic cv,
                                input logic pd, input logic bz);
      outs_t o;
      o.entry_ack = ack; o.entry_err = err; o.ticket_id = 3'(tid); o.exit_err = xerr;
      o.cost = CW'(c); o.cost_valid = cv; o.paid = pd; o.busy = bz;
      return o;
   endfunction

   function automatic outs_t actual();
      outs_t o;
      o.entry_ack = entry_ack; o.entry_err = entry_err; o.ticket_id = ticket_id;
      o.exit_err = exit_err; o.cost = cost; o.cost_valid = cost_valid;
      o.paid = paid; o.busy = busy;
      return o;
   endfunction

   function automatic int fee_of(input int stay);
      int f;
      f = RATE * (stay + 1);
      if (f > (1 << CW) - 1) f = (1 << CW) - 1;
`ifdef PARKING_FEE_CAP_EN
      if (f > MAX_FEE) f = MAX_FEE;
`endif
      return f;
   endfunction

   // Reference model: advances one clock with the inputs present at that edge and
   // leaves in m_exp the outputs required in the following cycle.
   task automatic modelStep(input stim_t s);
      bit old_occ [PMAX];
      int now_u;
      if (s.rst) begin
         foreach (m_occ[i]) begin m_occ[i] = 0; m_stamp[i] = 0; end
         m_cyc = 0; m_stage = NO_SETTLE; m_slot = 0;
         m_exp = '0;
         return;
      end
      now_u   = (m_cyc / TPU) % (1 << TW);
      old_occ = m_occ;
      m_exp.entry_ack = 0; m_exp.entry_err = 0; m_exp.exit_err = 0;
      case (m_stage)
         NO_SETTLE: if (s.exit_req) begin
            if (int'(s.exit_id) < PMAX && old_occ[s.exit_id]) begin
               m_slot = int'(s.exit_id); m_stage = PRICING;
            end else begin
               m_exp.exit_err = 1;
            end
         end
         PRICING: begin
            m_exp.cost = CW'(fee_of((now_u - m_stamp[m_slot]) & ((1 << TW) - 1)));
            m_stage = AWAIT_PAY;
         end
         AWAIT_PAY: if (s.pay) m_stage = RELEASING;
         default: begin
            m_occ[m_slot] = 0;
            m_stage = NO_SETTLE;
         end
      endcase
      if (s.entry) begin
         int slot;
         slot = -1;
         for (int i = PMAX - 1; i >= 0; i--) if (!old_occ[i]) slot = i;
         if (slot >= 0) begin
            m_exp.entry_ack = 1; m_exp.ticket_id = 3'(slot);
            m_occ[slot] = 1; m_stamp[slot] = now_u;
         end else begin
            m_exp.entry_err = 1;
         end
      end
      m_exp.cost_valid = (m_stage == AWAIT_PAY);
      m_exp.paid       = (m_stage == RELEASING);
      m_exp.busy       = (m_stage != NO_SETTLE);
      m_cyc++;
   endtask

   task automatic checkVec(input string name, input outs_t got, input outs_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got ack=%b err=%b tid=%0d xerr=%b cost=%0d cv=%b paid=%b busy=%b, expected ack=%b err=%b tid=%0d xerr=%b cost=%0d cv=%b paid=%b busy=%b",
                  name, got.entry_ack, got.entry_err, got.ticket_id, got.exit_err, got.cost,
                  got.cost_valid, got.paid, got.busy, exp.entry_ack, exp.entry_err,
                  exp.ticket_id, exp.exit_err, exp.cost, exp.cost_valid, exp.paid, exp.busy);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      checkVec(name, actual(), m_exp);
   endtask

   task automatic applyStimulus(input stim_t s, input string name);
      rst = s.rst; entry_evt = s.entry; exit_req = s.exit_req;
      exit_id = s.exit_id; pay = s.pay;
      @(posedge clk);
      modelStep(s);
      #1;
      rst = 0; entry_evt = 0; exit_req = 0; exit_id = '0; pay = 0;
      checkOutput(name);
   endtask

   task automatic runUntil(input int target);
      while (m_cyc < target) applyStimulus(mk(0, 0, 0, 0, 0), "idle");
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t tbl [$];
      int   cap_fee;
`ifdef PARKING_FEE_CAP_EN
      cap_fee = MAX_FEE;
`else
      cap_fee = 255;
`endif

      // Directed table: reset, fill, full, bad exits, settle of slot 0, reuse.
      tbl.push_back('{mk(0,0,0,0,0), mo(0,0,0,0,0,0,0,0)});
      tbl.push_back('{mk(0,0,1,2,0), mo(0,0,0,1,0,0,0,0)});
      tbl.push_back('{mk(0,1,0,0,0), mo(1,0,0,0,0,0,0,0)});
      tbl.push_back('{mk(0,1,1,1,0), mo(1,0,1,1,0,0,0,0)});
      tbl.push_back('{mk(0,1,0,0,0), mo(1,0,2,0,0,0,0,0)});
      tbl.push_back('{mk(0,1,0,0,0), mo(1,0,3,0,0,0,0,0)});
      tbl.push_back('{mk(0,1,0,0,0), mo(1,0,4,0,0,0,0,0)});
      tbl.push_back('{mk(0,1,0,0,0), mo(0,1,4,0,0,0,0,0)});
      tbl.push_back('{mk(0,0,1,6,0), mo(0,0,4,1,0,0,0,0)});
      tbl.push_back('{mk(0,0,1,7,0), mo(0,0,4,1,0,0,0,0)});
      tbl.push_back('{mk(0,0,1,0,0), mo(0,0,4,0,0,0,0,1)});
      tbl.push_back('{mk(0,0,0,0,0), mo(0,0,4,0,6,1,0,1)});
      tbl.push_back('{mk(0,0,1,1,0), mo(0,0,4,0,6,1,0,1)});
      tbl.push_back('{mk(0,0,0,0,1), mo(0,0,4,0,6,0,1,1)});
      tbl.push_back('{mk(0,1,0,0,0), mo(0,1,4,0,6,0,0,0)});
      tbl.push_back('{mk(0,1,0,0,0), mo(1,0,0,0,6,0,0,0)});
      tbl.push_back('{mk(0,0,0,0,1), mo(0,0,0,0,6,0,0,0)});

      applyStimulus(mk(1, 0, 0, 0, 0), "reset");
      checkVec("reset_zero", actual(), '0);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].stim, $sformatf("table_model_%0d", i));
         checkVec($sformatf("table_%0d", i), actual(), tbl[i].exp);
      end

      // Ten-unit stay, concurrent entry with the exit, then slot 0 reused.
      applyStimulus(mk(1, 0, 0, 0, 0), "t2_reset");
      applyStimulus(mk(0, 1, 0, 0, 0), "t2_entry");
      checkValue("t2_ticket0", ticket_id, 0);
      runUntil(39);
      applyStimulus(mk(0, 1, 1, 0, 0), "t2_exit_and_entry");
      checkValue("t2_ticket1", ticket_id, 1);
      checkValue("t2_calc_cv", cost_valid, 0);
      applyStimulus(mk(0, 0, 0, 0, 0), "t2_calc");
      checkValue("t2_cv", cost_valid, 1);
      checkValue("t2_cost", cost, 22);
      applyStimulus(mk(0, 0, 0, 0, 1), "t2_pay");
      checkValue("t2_paid", paid, 1);
      applyStimulus(mk(0, 0, 0, 0, 0), "t2_idle");
      applyStimulus(mk(0, 1, 0, 0, 0), "t2_reuse");
      checkValue("t2_reuse_ticket", ticket_id, 0);

      // Long stay hits the ceiling.
      applyStimulus(mk(1, 0, 0, 0, 0), "t4_reset");
      applyStimulus(mk(0, 1, 0, 0, 0), "t4_entry");
      runUntil(795);
      applyStimulus(mk(0, 0, 1, 0, 0), "t4_exit");
      applyStimulus(mk(0, 0, 0, 0, 0), "t4_calc");
      checkValue("t4_long_cost", cost, cap_fee);
      applyStimulus(mk(0, 0, 0, 0, 1), "t4_pay");
      applyStimulus(mk(0, 0, 0, 0, 0), "t4_idle");

      // Stamp at now=0xFE, priced at now=0x01 after the wrap.
      applyStimulus(mk(1, 0, 0, 0, 0), "t4w_reset");
      runUntil(1016);
      applyStimulus(mk(0, 1, 0, 0, 0), "t4w_entry");
      runUntil(1027);
      applyStimulus(mk(0, 0, 1, 0, 0), "t4w_exit");
      applyStimulus(mk(0, 0, 0, 0, 0), "t4w_calc");
      checkValue("t4w_wrap_cost", cost, 8);

      // Entry and ignored exit while waiting to pay, then reset mid-settle.
      applyStimulus(mk(1, 0, 0, 0, 0), "t5_reset");
      applyStimulus(mk(0, 1, 0, 0, 0), "t5_entry");
      applyStimulus(mk(0, 0, 1, 0, 0), "t5_exit");
      applyStimulus(mk(0, 0, 0, 0, 0), "t5_calc");
      checkValue("t5_cost", cost, 2);
      applyStimulus(mk(0, 1, 0, 0, 0), "t5_entry_wait");
      checkValue("t5_ticket1", ticket_id, 1);
      checkValue("t5_cost_held", cost, 2);
      applyStimulus(mk(0, 0, 1, 1, 0), "t5_exit_ignored");
      checkValue("t5_no_exit_err", exit_err, 0);
      checkValue("t5_still_wait", cost_valid, 1);
      applyStimulus(mk(1, 0, 0, 0, 0), "t5_mid_reset");
      checkVec("t5_reset_zero", actual(), '0);
      applyStimulus(mk(0, 0, 1, 1, 0), "t5_lost_ticket");
      checkValue("t5_lost_exit_err", exit_err, 1);
      applyStimulus(mk(0, 1, 0, 0, 0), "t5_entry_after_reset");
      checkValue("t5_ticket0", ticket_id, 0);

      // Randomized traffic against the model.
      applyStimulus(mk(1, 0, 0, 0, 0), "rnd_reset");
      for (int i = 0; i < 3000; i++) begin
         stim_t s;
         s.rst      = ($urandom_range(0, 299) == 0);
         s.entry    = ($urandom_range(0, 2) == 0);
         s.exit_req = ($urandom_range(0, 3) == 0);
         s.exit_id  = 3'($urandom_range(0, 7));
         s.pay      = ($urandom_range(0, 3) == 0);
         applyStimulus(s, $sformatf("random_%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
